imem_loader: RTL and testbench

- Writer side of the instruction memory. Receives a framed byte stream (header, payload, checksum) over a valid/ready interface.
- Assembles little-endian 32-bit instruction words and issues single-cycle writes to the instruction-memory write port.
- Holds the core off (cpu_hold) while loading, then reports done or error.
- Sits between the host UART/debug byte source and the instruction ROM array.

---
 rtl/imem_loader.sv | 136 +++++++++++++
 tb/tb_imem_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a framed byte stream (count, payload, checksum)
// and writes little-endian 32-bit words into the instruction memory while holding the core.
module imem_loader #(
  parameter int                DEPTH     = 1024,
  parameter int                ALEN      = 32,
  parameter int                XLEN      = 32,
  parameter logic [ALEN-1:0]   BASE_ADDR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            imem_we,
  output logic [ALEN-1:0] imem_addr,
  output logic [XLEN-1:0] imem_wdata,
  output logic [ALEN-1:0] words_written,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic            cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t      state;
  logic [1:0]  bcnt;
  logic [7:0]  csum;
  logic [31:0] len;
  logic [31:0] wbuf;
  logic        acc;
  logic [31:0] len_next;
  logic [31:0] word_next;

  assign acc       = in_valid && in_ready;
  // bytes arrive LSB first, so shifting in from the top leaves them little-endian
  assign len_next  = {in_data, len[31:8]};
  assign word_next = {in_data, wbuf[31:8]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      in_ready      <= 1'b0;
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      words_written <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      cpu_hold      <= 1'b0;
      bcnt          <= '0;
      csum          <= '0;
      len           <= '0;
      wbuf          <= '0;
    end else begin
      imem_we <= 1'b0;
      if (state == S_IDLE || state == S_DONE || state == S_ERROR) begin
        if (start) begin
          state         <= S_LEN;
          in_ready      <= 1'b1;
          busy          <= 1'b1;
          cpu_hold      <= 1'b1;
          done          <= 1'b0;
          error         <= 1'b0;
          words_written <= '0;
          bcnt          <= '0;
          csum          <= '0;
          len           <= '0;
        end
      end else if (abort) begin
        state    <= S_IDLE;
        in_ready <= 1'b0;
        busy     <= 1'b0;
        cpu_hold <= 1'b0;
        done     <= 1'b0;
        error    <= 1'b0;
      end else begin
        case (state)
          S_LEN: if (acc) begin
            len  <= len_next;
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              if (len_next > 32'(DEPTH)) begin
                state    <= S_ERROR;
                in_ready <= 1'b0;
                busy     <= 1'b0;
                cpu_hold <= 1'b0;
                error    <= 1'b1;
              end else if (len_next == 32'd0) begin
                state <= S_CHECK;
              end else begin
                state <= S_DATA;
              end
            end
          end
          S_DATA: if (acc) begin
            wbuf <= word_next;
            csum <= csum + in_data;
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              state      <= S_WRITE;
              in_ready   <= 1'b0;
              imem_we    <= 1'b1;
              imem_addr  <= BASE_ADDR + {words_written[ALEN-3:0], 2'b00};
              imem_wdata <= XLEN'(word_next);
            end
          end
          S_WRITE: begin
            words_written <= words_written + 1'b1;
            in_ready      <= 1'b1;
            state         <= (words_written == ALEN'(len - 32'd1)) ? S_CHECK : S_DATA;
          end
          S_CHECK: if (acc) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
            if (in_data == csum) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a frame-level model predicts writes and the final status.
module tb_imem_loader;
  localparam int DEPTH = 1024;

  logic        clk = 0, rst = 1, start = 0, abort = 0, in_valid = 0;
  logic [7:0]  in_data = 0;
  logic        in_ready, imem_we, busy, done, error, cpu_hold;
  logic [31:0] imem_addr, imem_wdata, words_written;

  imem_loader #(.DEPTH(DEPTH), .ALEN(32), .XLEN(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .words_written(words_written), .busy(busy), .done(done),
    .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [31:0] cap_addr[$], cap_data[$];
  int          we_while_ready = 0;
  logic [31:0] pay[$];

  always @(negedge clk) if (imem_we) begin
    cap_addr.push_back(imem_addr);
    cap_data.push_back(imem_wdata);
    if (in_ready !== 1'b0) we_while_ready++;
  end

  task automatic pulse_start();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok = 0;
    if (gaps && $urandom_range(1) == 0) begin
      @(negedge clk); in_valid = 0;
      repeat ($urandom_range(2)) @(negedge clk);
    end
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk); in_valid = 1; in_data = b;
      if (in_ready) begin @(posedge clk); ok = 1; end
    end
    if (!ok) begin
      failures++; checks++;
      $display("FAIL send_byte timeout byte=%02h", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
  endtask

  task automatic idle_in();
    @(negedge clk); in_valid = 0;
  endtask

  // Full load of the words in pay; model: writes go to 4*i, checksum is payload byte sum.
  task automatic run_load(input string name, input bit bad, input bit gaps);
    logic [7:0] ck = 0;
    logic [31:0] w;
    cap_addr.delete(); cap_data.delete(); we_while_ready = 0;
    foreach (pay[i]) ck += pay[i][7:0] + pay[i][15:8] + pay[i][23:16] + pay[i][31:24];
    pulse_start();
    send_word(pay.size(), gaps);
    foreach (pay[i]) send_word(pay[i], gaps);
    send_byte(bad ? ck + 8'd1 : ck, gaps);
    idle_in();
    checks++;
    if (cap_addr.size() !== pay.size()) begin
      failures++; $display("FAIL %s write_count got=%0d exp=%0d", name, cap_addr.size(), pay.size());
    end else begin
      foreach (pay[i]) begin
        w = 4 * i;
        checks++;
        if (cap_addr[i] !== w || cap_data[i] !== pay[i]) begin
          failures++;
          $display("FAIL %s write[%0d] got=%08h/%08h exp=%08h/%08h", name, i, cap_addr[i], cap_data[i], w, pay[i]);
        end
      end
    end
    checks++;
    if ({done, error, busy, cpu_hold, in_ready} !== {!bad, bad, 3'b000} || words_written !== pay.size()) begin
      failures++;
      $display("FAIL %s status got d/e/b/h/r=%b%b%b%b%b ww=%0d exp=%b%b000 ww=%0d", name,
               done, error, busy, cpu_hold, in_ready, words_written, !bad, bad, pay.size());
    end
    checks++;
    if (we_while_ready != 0) begin
      failures++; $display("FAIL %s in_ready_during_write got=%0d exp=0", name, we_while_ready);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, imem_we, busy, done, error, cpu_hold} !== 6'b0 || imem_addr !== 0 ||
        imem_wdata !== 0 || words_written !== 0) begin
      failures++; $display("FAIL reset got r/we/b/d/e/h=%b%b%b%b%b%b exp=000000",
                           in_ready, imem_we, busy, done, error, cpu_hold);
    end
  endtask

  task automatic test_basic();
    pay = '{32'h0000_0013, 32'h0010_0093};
    run_load("basic", 0, 0);
    run_load("bad_cksum", 1, 0);
  endtask

  task automatic test_too_long();
    cap_addr.delete();
    pulse_start();
    send_word(DEPTH + 1, 0);
    @(negedge clk); in_valid = 1; in_data = 8'h55;
    repeat (3) @(negedge clk);
    checks++;
    if ({error, done, busy, in_ready} !== 4'b1000 || cap_addr.size() != 0) begin
      failures++; $display("FAIL too_long got e/d/b/r=%b%b%b%b writes=%0d exp=1000 writes=0",
                           error, done, busy, in_ready, cap_addr.size());
    end
    idle_in();
  endtask

  task automatic test_zero_len();
    pay.delete();
    run_load("zero_good", 0, 0);
    run_load("zero_bad", 1, 0);
  endtask

  task automatic test_gaps();
    pay.delete();
    repeat (3) pay.push_back($urandom);
    run_load("gap_ref", 0, 0);
    run_load("gap_50", 0, 1);
    for (int r = 0; r < 4; r++) begin
      pay.delete();
      repeat ($urandom_range(6, 1)) pay.push_back($urandom);
      run_load("random", $urandom_range(1) == 1, 1);
    end
  endtask

  task automatic test_abort();
    pay = '{32'hDEAD_BEEF, 32'h1234_5678};
    cap_addr.delete(); cap_data.delete();
    pulse_start();
    send_word(2, 0);
    send_word(pay[0], 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    @(negedge clk); in_valid = 0; abort = 1;
    @(negedge clk); abort = 0;
    checks++;
    if (cap_addr.size() != 1 || cap_addr[0] !== 0 || cap_data[0] !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL abort_writes got=%0d exp=1 at addr 0", cap_addr.size());
    end
    checks++;
    if ({busy, done, error, cpu_hold, in_ready} !== 5'b0) begin
      failures++; $display("FAIL abort_status got b/d/e/h/r=%b%b%b%b%b exp=00000",
                           busy, done, error, cpu_hold, in_ready);
    end
    pay = '{32'hCAFE_0001, 32'h0BAD_F00D, 32'h0000_00FF};
    run_load("after_abort", 0, 0);
  endtask

  task automatic test_rst_mid();
    pulse_start();
    send_word(3, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    @(negedge clk); in_valid = 0;
    #2 rst = 1;
    #1;
    checks++;
    if ({in_ready, imem_we, busy, done, error, cpu_hold} !== 6'b0 || imem_addr !== 0 ||
        imem_wdata !== 0 || words_written !== 0) begin
      failures++; $display("FAIL rst_mid got r/we/b/d/e/h=%b%b%b%b%b%b addr=%08h exp=000000 addr=0",
                           in_ready, imem_we, busy, done, error, cpu_hold, imem_addr);
    end
    @(negedge clk); rst = 0;
    pay = '{32'h0000_0013};
    run_load("after_rst", 0, 0);
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk); rst = 0;
    test_basic();
    test_too_long();
    test_zero_len();
    test_gaps();
    test_abort();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
